// File: rtl/hilo_muldiv_if.sv
// Pipeline-side bundle for the HI/LO multiply/divide unit.
// state_dbg encoding: 0 IDLE, 1 DIV_RUN, 2 DIV_FIX.
interface hilo_muldiv_if #(
  parameter int DATA_W = 32
);
  logic              we_hi;
  logic              we_lo;
  logic [DATA_W-1:0] hi_i;
  logic [DATA_W-1:0] lo_i;
  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              flush;
  logic              busy;
  logic              stall_o;
  logic              done;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic [1:0]        state_dbg;

  modport master (
    output we_hi, we_lo, hi_i, lo_i, start, op, src_a, src_b, flush,
    input  busy, stall_o, done, hi_o, lo_o, state_dbg
  );

  modport slave (
    input  we_hi, we_lo, hi_i, lo_i, start, op, src_a, src_b, flush,
    output busy, stall_o, done, hi_o, lo_o, state_dbg
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register unit with 1-cycle MULT/MULTU/MADD/MSUB and a restoring divider.
// Optional macro HILO_BYPASS_EN forwards same-cycle MTHI/MTLO data onto hi_o/lo_o.
module hilo_muldiv_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  hilo_muldiv_if.slave  bus
);

  localparam int W2 = 2 * DATA_W;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_MADD  = 3'd3;
  localparam logic [2:0] OP_MSUB  = 3'd4;
  localparam logic [2:0] OP_DIV   = 3'd5;
  localparam logic [2:0] OP_DIVU  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIV_RUN = 2'd1,
    S_DIV_FIX = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] hi_q, lo_q;
  logic [DATA_W-1:0] rem_q, quot_q, divisor_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              q_neg_q, r_neg_q;
  logic              done_q;

  // Handshake: start is a one-cycle pulse, taken only in IDLE with flush low;
  // while busy, start and direct writes are ignored and stall_o holds the pipe.
  logic op_valid, launch, is_div, div_zero, wr_hi, wr_lo;
  assign op_valid = (bus.op >= OP_MULT) && (bus.op <= OP_DIVU);
  assign launch   = (state_q == S_IDLE) && bus.start && !bus.flush && op_valid;
  assign is_div   = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
  assign div_zero = (bus.src_b == '0);
  assign wr_hi    = (state_q == S_IDLE) && bus.we_hi && !launch;
  assign wr_lo    = (state_q == S_IDLE) && bus.we_lo && !launch;

  // Products are formed modulo 2^(2*DATA_W); sign-extending first gives the signed product.
  logic [W2-1:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
  assign a_sx   = {{DATA_W{bus.src_a[DATA_W-1]}}, bus.src_a};
  assign b_sx   = {{DATA_W{bus.src_b[DATA_W-1]}}, bus.src_b};
  assign a_zx   = {{DATA_W{1'b0}}, bus.src_a};
  assign b_zx   = {{DATA_W{1'b0}}, bus.src_b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  logic              a_neg, b_neg;
  logic [DATA_W-1:0] abs_a, abs_b;
  assign a_neg = (bus.op == OP_DIV) && bus.src_a[DATA_W-1];
  assign b_neg = (bus.op == OP_DIV) && bus.src_b[DATA_W-1];
  assign abs_a = a_neg ? -bus.src_a : bus.src_a;
  assign abs_b = b_neg ? -bus.src_b : bus.src_b;

  // Restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] rem_step, quot_step;
  assign trial     = {rem_q, quot_q[DATA_W-1]} - {1'b0, divisor_q};
  assign rem_step  = trial[DATA_W] ? {rem_q[DATA_W-2:0], quot_q[DATA_W-1]} : trial[DATA_W-1:0];
  assign quot_step = {quot_q[DATA_W-2:0], ~trial[DATA_W]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    bus.busy    = 1'b0;
    bus.stall_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (launch && is_div && !div_zero) state_d = S_DIV_RUN;
      end
      S_DIV_RUN: begin
        bus.busy    = 1'b1;
        bus.stall_o = 1'b1;
        if (bus.flush)        state_d = S_IDLE;
        else if (cnt_q == '0) state_d = S_DIV_FIX;
      end
      S_DIV_FIX: begin
        bus.busy    = 1'b1;
        bus.stall_o = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q      <= '0;
      lo_q      <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (launch) begin
            case (bus.op)
              OP_MULT: begin
                {hi_q, lo_q} <= prod_s;
                done_q       <= 1'b1;
              end
              OP_MULTU: begin
                {hi_q, lo_q} <= prod_u;
                done_q       <= 1'b1;
              end
              OP_MADD: begin
                {hi_q, lo_q} <= {hi_q, lo_q} + prod_s;
                done_q       <= 1'b1;
              end
              OP_MSUB: begin
                {hi_q, lo_q} <= {hi_q, lo_q} - prod_s;
                done_q       <= 1'b1;
              end
              default: begin
                if (div_zero) begin
                  hi_q   <= bus.src_a;
                  lo_q   <= '1;
                  done_q <= 1'b1;
                end else begin
                  quot_q    <= abs_a;
                  divisor_q <= abs_b;
                  rem_q     <= '0;
                  cnt_q     <= CNT_W'(DATA_W - 1);
                  q_neg_q   <= a_neg ^ b_neg;
                  r_neg_q   <= a_neg;
                end
              end
            endcase
          end else begin
            if (wr_hi) hi_q <= bus.hi_i;
            if (wr_lo) lo_q <= bus.lo_i;
          end
        end
        S_DIV_RUN: begin
          if (!bus.flush) begin
            rem_q  <= rem_step;
            quot_q <= quot_step;
            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DIV_FIX: begin
          if (!bus.flush) begin
            lo_q   <= q_neg_q ? -quot_q : quot_q;
            hi_q   <= r_neg_q ? -rem_q : rem_q;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.done      = done_q;
  assign bus.state_dbg = state_q;

`ifdef HILO_BYPASS_EN
  assign bus.hi_o = wr_hi ? bus.hi_i : hi_q;
  assign bus.lo_o = wr_lo ? bus.lo_i : lo_q;
`else
  assign bus.hi_o = hi_q;
  assign bus.lo_o = lo_q;
`endif

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: vector table, corner sequences, random ops vs model.
module tb_hilo_muldiv_unit;

  localparam int DW  = 32;
  localparam int DIV_LAT = DW + 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [DW-1:0]   hi_m, lo_m;
  logic [2*DW-1:0] exp_q[$];

  hilo_muldiv_if #(.DATA_W(DW)) bus();

  hilo_muldiv_unit #(.DATA_W(DW), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi_pre;
    logic [31:0] lo_pre;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.we_hi = 1'b0;
    bus.we_lo = 1'b0;
    bus.hi_i  = '0;
    bus.lo_i  = '0;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.flush = 1'b0;
  endtask

  // driver: MTHI+MTLO in one cycle, then confirm the registers took it
  task automatic direct_write(input string name, input logic [31:0] h, input logic [31:0] l);
    bus.we_hi = 1'b1;
    bus.we_lo = 1'b1;
    bus.hi_i  = h;
    bus.lo_i  = l;
    step();
    bus.we_hi = 1'b0;
    bus.we_lo = 1'b0;
    chk({name, ".hi"}, 64'(bus.hi_o), 64'(h));
    chk({name, ".lo"}, 64'(bus.lo_o), 64'(l));
    hi_m = h;
    lo_m = l;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = o;
    bus.src_a = a;
    bus.src_b = b;
    step();
    bus.start = 1'b0;
    bus.op    = 3'd0;
  endtask

  // driver + scoreboard: launch, count busy/stall cycles until done, compare HI/LO
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int lat, busy_cnt, stall_cnt;
    logic [63:0] want;
    exp_q.push_back(exp);
    issue(o, a, b);
    lat = 0; busy_cnt = 0; stall_cnt = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.stall_o === 1'b1) stall_cnt++;
      step();
      lat++;
    end
    chk({name, ".done"}, 64'(bus.done), 64'(1));
    chk({name, ".lat"}, 64'(lat), 64'(exp_lat));
    chk({name, ".busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
    chk({name, ".stall_cycles"}, 64'(stall_cnt), 64'(exp_lat));
    chk({name, ".busy_at_done"}, 64'(bus.busy), 64'(0));
    want = exp_q.pop_front();
    chk({name, ".hi"}, 64'(bus.hi_o), 64'(want[63:32]));
    chk({name, ".lo"}, 64'(bus.lo_o), 64'(want[31:0]));
    hi_m = want[63:32];
    lo_m = want[31:0];
    step();
    chk({name, ".done_pulse"}, 64'(bus.done), 64'(0));
  endtask

  // reference model: plain arithmetic on 64-bit integers
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hl);
    longint sa, sb, q, m;
    logic [63:0] r, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      3'd1: r = 64'(sa * sb);
      3'd2: r = ua * ub;
      3'd3: r = hl + 64'(sa * sb);
      3'd4: r = hl - 64'(sa * sb);
      3'd5: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          m = sa % sb;
          r = {m[31:0], q[31:0]};
        end
      end
      3'd6: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
      default: r = hl;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'($urandom_range(0, 20));
      1: return -32'($urandom_range(1, 20));
      2: return 32'h0;
      3: return ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int done_seen;
    logic [2:0]  o;
    logic [31:0] a, b;
    logic [63:0] e;

    checks = 0;
    errors = 0;
    hi_m   = '0;
    lo_m   = '0;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("rst.hi", 64'(bus.hi_o), 64'(0));
    chk("rst.lo", 64'(bus.lo_o), 64'(0));
    chk("rst.busy", 64'(bus.busy), 64'(0));
    chk("rst.stall", 64'(bus.stall_o), 64'(0));
    chk("rst.done", 64'(bus.done), 64'(0));
    chk("rst.state", 64'(bus.state_dbg), 64'(0));
    step();
    step();
    rst_n = 1'b1;
    step();

    vecs.push_back('{"mult_neg",   3'd1, 32'hFFFF_FFFE, 32'd3,        32'h0, 32'h0,  64'hFFFF_FFFF_FFFF_FFFA, 0});
    vecs.push_back('{"multu",      3'd2, 32'hFFFF_FFFE, 32'd3,        32'h0, 32'h0,  64'h0000_0002_FFFF_FFFA, 0});
    vecs.push_back('{"multu_max",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 64'hFFFF_FFFE_0000_0001, 0});
    vecs.push_back('{"madd",       3'd3, 32'd4,         32'd5,        32'h0, 32'd10, 64'h0000_0000_0000_001E, 0});
    vecs.push_back('{"msub",       3'd4, 32'd7,         32'd5,        32'h0, 32'd30, 64'hFFFF_FFFF_FFFF_FFFB, 0});
    vecs.push_back('{"div_neg",    3'd5, 32'hFFFF_FFF9, 32'd2,        32'h0, 32'h0,  64'hFFFF_FFFF_FFFF_FFFD, DIV_LAT});
    vecs.push_back('{"div_negb",   3'd5, 32'd7,         32'hFFFF_FFFE, 32'h0, 32'h0, 64'h0000_0001_FFFF_FFFD, DIV_LAT});
    vecs.push_back('{"div_minm1",  3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 64'h0000_0000_8000_0000, DIV_LAT});
    vecs.push_back('{"divu",       3'd6, 32'd100,       32'd7,        32'h0, 32'h0,  64'h0000_0002_0000_000E, DIV_LAT});
    vecs.push_back('{"divu_zero",  3'd6, 32'd7,         32'd0,        32'h0, 32'h0,  64'h0000_0007_FFFF_FFFF, 0});
    vecs.push_back('{"div_zero",   3'd5, 32'hFFFF_FFFB, 32'd0,        32'h0, 32'h0,  64'hFFFF_FFFB_FFFF_FFFF, 0});

    foreach (vecs[i]) begin
      direct_write({vecs[i].name, ".pre"}, vecs[i].hi_pre, vecs[i].lo_pre);
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    end

    direct_write("mt", 32'h1234, 32'hABCD);

    // start blocked by flush in IDLE while direct write still lands
    bus.start = 1'b1; bus.op = 3'd1; bus.src_a = 32'd9; bus.src_b = 32'd9;
    bus.flush = 1'b1; bus.we_hi = 1'b1; bus.hi_i = 32'h77;
    step();
    idle_inputs();
    chk("idle_flush.done", 64'(bus.done), 64'(0));
    chk("idle_flush.hi", 64'(bus.hi_o), 64'(32'h77));
    chk("idle_flush.lo", 64'(bus.lo_o), 64'(32'hABCD));
    hi_m = 32'h77;

    // start beats a same-cycle direct write
    bus.we_hi = 1'b1; bus.we_lo = 1'b1; bus.hi_i = 32'h1; bus.lo_i = 32'h2;
    run_op("start_wins", 3'd2, 32'd6, 32'd7, 64'd42, 0);
    idle_inputs();

    // flush mid-divide, with ignored start and write while busy
    direct_write("fl.pre", 32'hAAAA_0000, 32'h0000_5555);
    issue(3'd6, 32'd100, 32'd7);
    step(); step();
    bus.start = 1'b1; bus.op = 3'd2; bus.src_a = 32'd3; bus.src_b = 32'd3;
    bus.we_hi = 1'b1; bus.hi_i = 32'hDEAD;
    step();
    idle_inputs();
    chk("fl.busy_mid", 64'(bus.busy), 64'(1));
    chk("fl.hi_mid", 64'(bus.hi_o), 64'(32'hAAAA_0000));
    chk("fl.lo_mid", 64'(bus.lo_o), 64'(32'h0000_5555));
    for (int i = 0; i < 6; i++) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("fl.busy", 64'(bus.busy), 64'(0));
    chk("fl.stall", 64'(bus.stall_o), 64'(0));
    chk("fl.done", 64'(bus.done), 64'(0));
    chk("fl.hi", 64'(bus.hi_o), 64'(32'hAAAA_0000));
    chk("fl.lo", 64'(bus.lo_o), 64'(32'h0000_5555));
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) done_seen++;
      step();
    end
    chk("fl.no_done", 64'(done_seen), 64'(0));
    run_op("fl.after", 3'd6, 32'd100, 32'd7, 64'h0000_0002_0000_000E, DIV_LAT);

    // bypass visibility of a direct write
    direct_write("byp.pre", 32'h0, 32'h1111);
    bus.we_lo = 1'b1; bus.lo_i = 32'h55;
    #1;
`ifdef HILO_BYPASS_EN
    chk("byp.same", 64'(bus.lo_o), 64'(32'h55));
`else
    chk("byp.same", 64'(bus.lo_o), 64'(32'h1111));
`endif
    step();
    bus.we_lo = 1'b0;
    chk("byp.next", 64'(bus.lo_o), 64'(32'h55));
    lo_m = 32'h55;

    // randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(1, 6));
      a = pick();
      b = pick();
      e = model(o, a, b, {hi_m, lo_m});
      run_op($sformatf("rnd%0d_op%0d", i, o), o, a, b, e,
             ((o == 3'd5 || o == 3'd6) && b != 0) ? DIV_LAT : 0);
    end

    // async reset mid-cycle during a divide
    direct_write("rstm.pre", 32'h1234, 32'hABCD);
    issue(3'd5, 32'd1000, 32'd3);
    step(); step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("rstm.hi", 64'(bus.hi_o), 64'(0));
    chk("rstm.lo", 64'(bus.lo_o), 64'(0));
    chk("rstm.busy", 64'(bus.busy), 64'(0));
    chk("rstm.state", 64'(bus.state_dbg), 64'(0));
    step();
    rst_n = 1'b1;
    hi_m = '0;
    lo_m = '0;
    step();
    chk("rstm.done", 64'(bus.done), 64'(0));
    run_op("rstm.madd", 3'd3, 32'd3, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
